// File: rtl/fx2_fifo_emu.sv
// fx2_fifo_emu: stand-in for the FX2 side of the slave-FIFO interface.
//
// The FPGA-side bus master talks to this block exactly as it would talk to the
// FX2 chip. Two FIFOs back the interface:
//   OUT (host -> FPGA): filled from the host port, drained by fx2_slrd.
//   IN  (FPGA -> host): filled by fx2_slwr, drained by the host port. Each entry
//                       carries an end-of-packet bit next to the data byte.
//
// Ports
//   fx2_clk, reset_n     clock, asynchronous active-low reset
//   fx2_slrd/slwr/sloe   active-low read / write / output-enable strobes
//   fx2_pktend           active-low packet commit
//   fx2_fifoadr          endpoint select (OUT_ADDR / IN_ADDR)
//   fx2_fd               bidirectional data bus
//   fx2_flags            {IN not-empty, IN not-full, OUT not-empty}, registered
//   host_out_*           host push port into the OUT FIFO
//   host_in_*            registered head of the IN FIFO and its pop strobe
//   zlp_count            wrapping count of zero-length packets
//   err_overflow         sticky: FPGA write while IN full
//   err_underflow        sticky: FPGA read while OUT empty
module fx2_fifo_emu #(
  parameter int unsigned OUT_DEPTH = 16,
  parameter int unsigned IN_DEPTH  = 16,
  parameter logic [1:0]  OUT_ADDR  = 2'b00,
  parameter logic [1:0]  IN_ADDR   = 2'b10
) (
  input  logic       fx2_clk,
  input  logic       reset_n,
  input  logic       fx2_slrd,
  input  logic       fx2_slwr,
  input  logic       fx2_sloe,
  input  logic       fx2_pktend,
  input  logic [1:0] fx2_fifoadr,
  inout  wire  [7:0] fx2_fd,
  output logic [2:0] fx2_flags,
  input  logic [7:0] host_out_data,
  input  logic       host_out_wr,
  output logic       host_out_full,
  output logic [7:0] host_in_data,
  output logic       host_in_last,
  output logic       host_in_valid,
  input  logic       host_in_rd,
  output logic [7:0] zlp_count,
  output logic       err_overflow,
  output logic       err_underflow
);

  localparam int unsigned OutPw = $clog2(OUT_DEPTH);
  localparam int unsigned OutCw = OutPw + 1;
  localparam int unsigned InPw  = $clog2(IN_DEPTH);
  localparam int unsigned InCw  = InPw + 1;

  localparam logic [OutCw-1:0] OutFullCnt = OutCw'(OUT_DEPTH);
  localparam logic [InCw-1:0]  InFullCnt  = InCw'(IN_DEPTH);

  // ---------------------------------------------------------------------------
  // OUT FIFO (host -> FPGA)
  // ---------------------------------------------------------------------------
  logic [7:0]       out_mem [OUT_DEPTH];
  logic [OutPw-1:0] out_wptr_q, out_rptr_q;
  logic [OutCw-1:0] out_cnt_q, out_cnt_d;
  logic             out_empty, out_full;
  logic             out_rd_req, out_push, out_pop;
  logic             out_drive;
  logic [7:0]       out_head;

  assign out_empty  = (out_cnt_q == '0);
  assign out_full   = (out_cnt_q == OutFullCnt);
  assign out_rd_req = !fx2_slrd && (fx2_fifoadr == OUT_ADDR);
  // A full FIFO rejects the push even if a pop happens in the same cycle.
  assign out_push   = host_out_wr && !out_full;
  assign out_pop    = out_rd_req && !out_empty;

  always_comb begin
    out_cnt_d = out_cnt_q;
    unique case ({out_push, out_pop})
      2'b10:   out_cnt_d = out_cnt_q + OutCw'(1);
      2'b01:   out_cnt_d = out_cnt_q - OutCw'(1);
      default: out_cnt_d = out_cnt_q;
    endcase
  end

  always_ff @(posedge fx2_clk or negedge reset_n) begin
    if (!reset_n) begin
      out_wptr_q <= '0;
      out_rptr_q <= '0;
      out_cnt_q  <= '0;
    end else begin
      if (out_push) out_wptr_q <= out_wptr_q + OutPw'(1);
      if (out_pop)  out_rptr_q <= out_rptr_q + OutPw'(1);
      out_cnt_q <= out_cnt_d;
    end
  end

  // Storage is not reset; the occupancy counter alone defines what is valid.
  always_ff @(posedge fx2_clk) begin
    if (out_push) out_mem[out_wptr_q] <= host_out_data;
  end

  // Combinational from the head so a pop shows the next byte on the next cycle.
  assign out_head  = out_empty ? 8'h00 : out_mem[out_rptr_q];
  assign out_drive = !fx2_sloe && (fx2_fifoadr == OUT_ADDR);
  assign fx2_fd    = out_drive ? out_head : 8'bz;

  // ---------------------------------------------------------------------------
  // IN FIFO (FPGA -> host), entries are {eop, data}
  // ---------------------------------------------------------------------------
  logic [8:0]      in_mem [IN_DEPTH];
  logic [InPw-1:0] in_wptr_q, in_rptr_q, in_rptr_d, in_last_idx;
  logic [InCw-1:0] in_cnt_q, in_cnt_d;
  logic            in_empty, in_full;
  logic            in_wr_req, in_commit, in_push, in_pop, in_tag;
  logic [8:0]      in_entry, in_head_d;

  assign in_empty    = (in_cnt_q == '0);
  assign in_full     = (in_cnt_q == InFullCnt);
  assign in_wr_req   = !fx2_slwr && (fx2_fifoadr == IN_ADDR);
  assign in_commit   = !fx2_pktend && fx2_slwr && (fx2_fifoadr == IN_ADDR);
  assign in_push     = in_wr_req && !in_full;
  assign in_pop      = host_in_rd && !in_empty;
  // Standalone pktend marks the newest entry; with nothing queued it is a ZLP.
  assign in_tag      = in_commit && !in_empty;
  assign in_entry    = {!fx2_pktend, fx2_fd};
  assign in_last_idx = in_wptr_q - InPw'(1);

  always_comb begin
    in_cnt_d = in_cnt_q;
    unique case ({in_push, in_pop})
      2'b10:   in_cnt_d = in_cnt_q + InCw'(1);
      2'b01:   in_cnt_d = in_cnt_q - InCw'(1);
      default: in_cnt_d = in_cnt_q;
    endcase
  end

  // Post-edge head entry, including a push or eop tag landing this cycle, so
  // the registered host outputs need no extra cycle of lag.
  always_comb begin
    in_rptr_d = in_pop ? (in_rptr_q + InPw'(1)) : in_rptr_q;
    in_head_d = in_mem[in_rptr_d];
    if (in_push && (in_wptr_q == in_rptr_d)) in_head_d = in_entry;
    if (in_tag && (in_last_idx == in_rptr_d)) in_head_d[8] = 1'b1;
    if (in_cnt_d == '0) in_head_d = '0;
  end

  always_ff @(posedge fx2_clk or negedge reset_n) begin
    if (!reset_n) begin
      in_wptr_q <= '0;
      in_rptr_q <= '0;
      in_cnt_q  <= '0;
    end else begin
      if (in_push) in_wptr_q <= in_wptr_q + InPw'(1);
      in_rptr_q <= in_rptr_d;
      in_cnt_q  <= in_cnt_d;
    end
  end

  // Push and tag never coincide: a tag requires fx2_slwr high.
  always_ff @(posedge fx2_clk) begin
    if (in_push) in_mem[in_wptr_q] <= in_entry;
    if (in_tag)  in_mem[in_last_idx][8] <= 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Registered status, all computed from post-edge occupancy
  // ---------------------------------------------------------------------------
  always_ff @(posedge fx2_clk or negedge reset_n) begin
    if (!reset_n) begin
      fx2_flags     <= 3'b010;
      host_out_full <= 1'b0;
      host_in_valid <= 1'b0;
      host_in_data  <= 8'h00;
      host_in_last  <= 1'b0;
      zlp_count     <= 8'h00;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      fx2_flags[0]  <= (out_cnt_d != '0);
      fx2_flags[1]  <= (in_cnt_d != InFullCnt);
      fx2_flags[2]  <= (in_cnt_d != '0);
      host_out_full <= (out_cnt_d == OutFullCnt);
      host_in_valid <= (in_cnt_d != '0);
      host_in_data  <= in_head_d[7:0];
      host_in_last  <= in_head_d[8];
      if (in_commit && in_empty) zlp_count <= zlp_count + 8'd1;
      if (in_wr_req && in_full)  err_overflow <= 1'b1;
      if (out_rd_req && out_empty) err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fx2_fifo_emu.sv
module tb_fx2_fifo_emu;

  logic       clk;
  logic       reset_n;
  logic       slrd, slwr, sloe, pktend;
  logic [1:0] fifoadr;
  wire  [7:0] fd;
  logic [7:0] tb_fd;
  logic       tb_fd_en;
  logic [2:0] flags;
  logic [7:0] host_out_data;
  logic       host_out_wr;
  logic       host_out_full;
  logic [7:0] host_in_data;
  logic       host_in_last;
  logic       host_in_valid;
  logic       host_in_rd;
  logic [7:0] zlp_count;
  logic       err_overflow;
  logic       err_underflow;

  int checks = 0;
  int errors = 0;

  assign fd = tb_fd_en ? tb_fd : 8'bz;

  fx2_fifo_emu dut (
    .fx2_clk       (clk),
    .reset_n       (reset_n),
    .fx2_slrd      (slrd),
    .fx2_slwr      (slwr),
    .fx2_sloe      (sloe),
    .fx2_pktend    (pktend),
    .fx2_fifoadr   (fifoadr),
    .fx2_fd        (fd),
    .fx2_flags     (flags),
    .host_out_data (host_out_data),
    .host_out_wr   (host_out_wr),
    .host_out_full (host_out_full),
    .host_in_data  (host_in_data),
    .host_in_last  (host_in_last),
    .host_in_valid (host_in_valid),
    .host_in_rd    (host_in_rd),
    .zlp_count     (zlp_count),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       host_wr;
    logic [7:0] host_d;
    logic       host_rd;
    logic [1:0] addr;
    logic       sloe, slrd, slwr, pktend;
    logic [7:0] fd;
    logic [2:0] e_flags;
    logic       e_ofull, e_valid;
    logic [7:0] e_data;
    logic       e_last, e_fdchk;
    logic [7:0] e_fd, e_zlp;
    logic       e_ovf, e_unf;
  } vec_t;

  function automatic vec_t mk(
    input logic hw, input logic [7:0] hd, input logic hr, input logic [1:0] a,
    input logic oe, input logic rd, input logic wr, input logic pe, input logic [7:0] d,
    input logic [2:0] ef, input logic eof, input logic ev, input logic [7:0] ed,
    input logic el, input logic efc, input logic [7:0] efd, input logic [7:0] ez,
    input logic eo, input logic eu);
    vec_t v;
    v.host_wr = hw; v.host_d = hd; v.host_rd = hr; v.addr = a;
    v.sloe = oe; v.slrd = rd; v.slwr = wr; v.pktend = pe; v.fd = d;
    v.e_flags = ef; v.e_ofull = eof; v.e_valid = ev; v.e_data = ed; v.e_last = el;
    v.e_fdchk = efc; v.e_fd = efd; v.e_zlp = ez; v.e_ovf = eo; v.e_unf = eu;
    return v;
  endfunction

  // Input-only record for the hand-written sequences.
  function automatic vec_t in_only(
    input logic hw, input logic [7:0] hd, input logic hr, input logic [1:0] a,
    input logic oe, input logic rd, input logic wr, input logic pe, input logic [7:0] d);
    return mk(hw, hd, hr, a, oe, rd, wr, pe, d, 3'b000, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0);
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs after the falling edge, sample 1 ns past the
  // rising edge while the inputs are still held.
  task automatic apply(input vec_t v);
    @(negedge clk);
    host_out_wr   = v.host_wr;
    host_out_data = v.host_d;
    host_in_rd    = v.host_rd;
    fifoadr       = v.addr;
    sloe          = v.sloe;
    slrd          = v.slrd;
    slwr          = v.slwr;
    pktend        = v.pktend;
    tb_fd         = v.fd;
    tb_fd_en      = !v.slwr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    apply(in_only(0, 8'h00, 0, 2'b00, 1, 1, 1, 1, 8'h00));
  endtask

  vec_t tbl [30];

  initial begin
    // hw  hd     hr addr  oe rd wr pe fd     flags  of v data  l fc fd     zlp  ov un
    tbl[0]  = mk(1, 8'hA1, 0, 2'b00, 1, 1, 1, 1, 8'h00, 3'b011, 0, 0, 8'h00, 0, 0, 8'h00, 8'd0, 0, 0);
    tbl[1]  = mk(1, 8'hB2, 0, 2'b00, 1, 1, 1, 1, 8'h00, 3'b011, 0, 0, 8'h00, 0, 0, 8'h00, 8'd0, 0, 0);
    tbl[2]  = mk(1, 8'hC3, 0, 2'b00, 1, 1, 1, 1, 8'h00, 3'b011, 0, 0, 8'h00, 0, 0, 8'h00, 8'd0, 0, 0);
    tbl[3]  = mk(0, 8'h00, 0, 2'b00, 0, 1, 1, 1, 8'h00, 3'b011, 0, 0, 8'h00, 0, 1, 8'hA1, 8'd0, 0, 0);
    tbl[4]  = mk(0, 8'h00, 0, 2'b00, 0, 0, 1, 1, 8'h00, 3'b011, 0, 0, 8'h00, 0, 1, 8'hB2, 8'd0, 0, 0);
    tbl[5]  = mk(0, 8'h00, 0, 2'b00, 0, 0, 1, 1, 8'h00, 3'b011, 0, 0, 8'h00, 0, 1, 8'hC3, 8'd0, 0, 0);
    tbl[6]  = mk(0, 8'h00, 0, 2'b00, 0, 0, 1, 1, 8'h00, 3'b010, 0, 0, 8'h00, 0, 1, 8'h00, 8'd0, 0, 0);
    tbl[7]  = mk(0, 8'h00, 0, 2'b00, 1, 1, 1, 1, 8'h00, 3'b010, 0, 0, 8'h00, 0, 0, 8'h00, 8'd0, 0, 0);
    tbl[8]  = mk(0, 8'h00, 0, 2'b10, 1, 1, 0, 1, 8'h10, 3'b110, 0, 1, 8'h10, 0, 0, 8'h00, 8'd0, 0, 0);
    tbl[9]  = mk(0, 8'h00, 0, 2'b10, 1, 1, 0, 1, 8'h11, 3'b110, 0, 1, 8'h10, 0, 0, 8'h00, 8'd0, 0, 0);
    tbl[10] = mk(0, 8'h00, 0, 2'b10, 1, 1, 0, 1, 8'h12, 3'b110, 0, 1, 8'h10, 0, 0, 8'h00, 8'd0, 0, 0);
    tbl[11] = mk(0, 8'h00, 0, 2'b10, 1, 1, 0, 0, 8'h13, 3'b110, 0, 1, 8'h10, 0, 0, 8'h00, 8'd0, 0, 0);
    tbl[12] = mk(0, 8'h00, 1, 2'b10, 1, 1, 1, 1, 8'h00, 3'b110, 0, 1, 8'h11, 0, 0, 8'h00, 8'd0, 0, 0);
    tbl[13] = mk(0, 8'h00, 1, 2'b10, 1, 1, 1, 1, 8'h00, 3'b110, 0, 1, 8'h12, 0, 0, 8'h00, 8'd0, 0, 0);
    tbl[14] = mk(0, 8'h00, 1, 2'b10, 1, 1, 1, 1, 8'h00, 3'b110, 0, 1, 8'h13, 1, 0, 8'h00, 8'd0, 0, 0);
    tbl[15] = mk(0, 8'h00, 1, 2'b10, 1, 1, 1, 1, 8'h00, 3'b010, 0, 0, 8'h00, 0, 0, 8'h00, 8'd0, 0, 0);
    tbl[16] = mk(0, 8'h00, 0, 2'b10, 1, 1, 1, 0, 8'h00, 3'b010, 0, 0, 8'h00, 0, 0, 8'h00, 8'd1, 0, 0);
    tbl[17] = mk(0, 8'h00, 0, 2'b10, 1, 1, 0, 1, 8'h55, 3'b110, 0, 1, 8'h55, 0, 0, 8'h00, 8'd1, 0, 0);
    tbl[18] = mk(0, 8'h00, 0, 2'b10, 1, 1, 1, 0, 8'h00, 3'b110, 0, 1, 8'h55, 1, 0, 8'h00, 8'd1, 0, 0);
    tbl[19] = mk(0, 8'h00, 1, 2'b10, 1, 1, 1, 1, 8'h00, 3'b010, 0, 0, 8'h00, 0, 0, 8'h00, 8'd1, 0, 0);
    tbl[20] = mk(0, 8'h00, 0, 2'b01, 1, 1, 0, 0, 8'h77, 3'b010, 0, 0, 8'h00, 0, 0, 8'h00, 8'd1, 0, 0);
    tbl[21] = mk(0, 8'h00, 0, 2'b10, 0, 0, 1, 1, 8'h00, 3'b010, 0, 0, 8'h00, 0, 0, 8'h00, 8'd1, 0, 0);
    tbl[22] = mk(0, 8'h00, 0, 2'b00, 0, 0, 1, 1, 8'h00, 3'b010, 0, 0, 8'h00, 0, 1, 8'h00, 8'd1, 0, 1);
    tbl[23] = mk(0, 8'h00, 0, 2'b10, 1, 1, 0, 1, 8'h21, 3'b110, 0, 1, 8'h21, 0, 0, 8'h00, 8'd1, 0, 1);
    tbl[24] = mk(0, 8'h00, 1, 2'b10, 1, 1, 0, 1, 8'h22, 3'b110, 0, 1, 8'h22, 0, 0, 8'h00, 8'd1, 0, 1);
    tbl[25] = mk(0, 8'h00, 1, 2'b10, 1, 1, 1, 1, 8'h00, 3'b010, 0, 0, 8'h00, 0, 0, 8'h00, 8'd1, 0, 1);
    tbl[26] = mk(0, 8'h00, 1, 2'b10, 1, 1, 0, 1, 8'h33, 3'b110, 0, 1, 8'h33, 0, 0, 8'h00, 8'd1, 0, 1);
    tbl[27] = mk(0, 8'h00, 1, 2'b10, 1, 1, 1, 1, 8'h00, 3'b010, 0, 0, 8'h00, 0, 0, 8'h00, 8'd1, 0, 1);
    tbl[28] = mk(1, 8'h44, 0, 2'b00, 0, 0, 1, 1, 8'h00, 3'b011, 0, 0, 8'h00, 0, 1, 8'h44, 8'd1, 0, 1);
    tbl[29] = mk(0, 8'h00, 0, 2'b00, 0, 0, 1, 1, 8'h00, 3'b010, 0, 0, 8'h00, 0, 1, 8'h00, 8'd1, 0, 1);

    reset_n = 1'b0;
    host_out_wr = 1'b0; host_out_data = 8'h00; host_in_rd = 1'b0;
    fifoadr = 2'b00; sloe = 1'b1; slrd = 1'b1; slwr = 1'b1; pktend = 1'b1;
    tb_fd = 8'h00; tb_fd_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset flags", {5'b0, flags}, 8'h02);
    check("reset out_full", {7'b0, host_out_full}, 8'h00);
    check("reset in_valid", {7'b0, host_in_valid}, 8'h00);
    check("reset in_data", host_in_data, 8'h00);
    check("reset in_last", {7'b0, host_in_last}, 8'h00);
    check("reset zlp", zlp_count, 8'h00);
    check("reset errs", {6'b0, err_overflow, err_underflow}, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;

    // Table-driven single-cycle vectors.
    for (int i = 0; i < 30; i++) begin
      apply(tbl[i]);
      check($sformatf("v%0d flags", i), {5'b0, flags}, {5'b0, tbl[i].e_flags});
      check($sformatf("v%0d out_full", i), {7'b0, host_out_full}, {7'b0, tbl[i].e_ofull});
      check($sformatf("v%0d in_valid", i), {7'b0, host_in_valid}, {7'b0, tbl[i].e_valid});
      check($sformatf("v%0d in_data", i), host_in_data, tbl[i].e_data);
      check($sformatf("v%0d in_last", i), {7'b0, host_in_last}, {7'b0, tbl[i].e_last});
      check($sformatf("v%0d zlp", i), zlp_count, tbl[i].e_zlp);
      check($sformatf("v%0d errs", i), {6'b0, err_overflow, err_underflow},
            {6'b0, tbl[i].e_ovf, tbl[i].e_unf});
      if (tbl[i].e_fdchk) check($sformatf("v%0d fd", i), fd, tbl[i].e_fd);
    end
    idle();

    // IN full and overflow: 17 writes, no host reads.
    for (int i = 0; i < 16; i++) begin
      apply(in_only(0, 8'h00, 0, 2'b10, 1, 1, 0, 1, 8'(8'h80 + i)));
      check($sformatf("fill%0d in_notfull", i), {7'b0, flags[1]}, (i < 15) ? 8'h01 : 8'h00);
    end
    check("fill ovf before", {7'b0, err_overflow}, 8'h00);
    apply(in_only(0, 8'h00, 0, 2'b10, 1, 1, 0, 1, 8'hEE));
    check("ovf flag", {7'b0, err_overflow}, 8'h01);
    check("ovf in_notfull", {7'b0, flags[1]}, 8'h00);
    idle();
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain%0d valid", i), {7'b0, host_in_valid}, 8'h01);
      check($sformatf("drain%0d data", i), host_in_data, 8'(8'h80 + i));
      apply(in_only(0, 8'h00, 1, 2'b10, 1, 1, 1, 1, 8'h00));
    end
    check("drain empty", {7'b0, host_in_valid}, 8'h00);
    check("drain flags", {5'b0, flags}, 8'h02);

    // OUT full from the host side: 17th push dropped without an error.
    for (int i = 0; i < 17; i++) begin
      apply(in_only(1, 8'(8'hC0 + i), 0, 2'b00, 1, 1, 1, 1, 8'h00));
      check($sformatf("ofill%0d full", i), {7'b0, host_out_full}, (i >= 15) ? 8'h01 : 8'h00);
    end
    apply(in_only(0, 8'h00, 0, 2'b00, 0, 1, 1, 1, 8'h00));
    check("ofull head", fd, 8'hC0);
    for (int i = 0; i < 16; i++) begin
      apply(in_only(0, 8'h00, 0, 2'b00, 0, 0, 1, 1, 8'h00));
      check($sformatf("odrain%0d fd", i), fd, (i < 15) ? 8'(8'hC1 + i) : 8'h00);
      check($sformatf("odrain%0d full", i), {7'b0, host_out_full}, 8'h00);
    end
    check("odrain flag0", {7'b0, flags[0]}, 8'h00);
    check("odrain ovf kept", {7'b0, err_overflow}, 8'h01);

    // Wrap-around: push and pop every cycle, 40 bytes through a 16-deep FIFO.
    for (int k = 0; k < 40; k++) begin
      apply(in_only(1, 8'(8'h40 + k), 0, 2'b00, 0, 0, 1, 1, 8'h00));
      check($sformatf("wrap%0d fd", k), fd, 8'(8'h40 + k));
      check($sformatf("wrap%0d flags", k), {5'b0, flags}, 8'h03);
      check($sformatf("wrap%0d full", k), {7'b0, host_out_full}, 8'h00);
    end
    apply(in_only(0, 8'h00, 0, 2'b00, 0, 0, 1, 1, 8'h00));
    check("wrap end fd", fd, 8'h00);
    check("wrap end flag0", {7'b0, flags[0]}, 8'h00);

    // Reset mid-transfer with 5 bytes in each FIFO.
    for (int i = 0; i < 5; i++) begin
      apply(in_only(1, 8'(8'h60 + i), 0, 2'b10, 1, 1, 0, 1, 8'(8'h70 + i)));
    end
    check("pre-reset flags", {5'b0, flags}, 8'h07);
    check("pre-reset in_data", host_in_data, 8'h70);
    @(negedge clk);
    host_out_wr = 1'b0; slwr = 1'b1; tb_fd_en = 1'b0; fifoadr = 2'b00; sloe = 1'b0;
    #1;
    check("pre-reset fd", fd, 8'h60);
    #1;
    reset_n = 1'b0;
    #1;
    check("mid-reset flags", {5'b0, flags}, 8'h02);
    check("mid-reset in_valid", {7'b0, host_in_valid}, 8'h00);
    check("mid-reset in_data", host_in_data, 8'h00);
    check("mid-reset in_last", {7'b0, host_in_last}, 8'h00);
    check("mid-reset out_full", {7'b0, host_out_full}, 8'h00);
    check("mid-reset zlp", zlp_count, 8'h00);
    check("mid-reset errs", {6'b0, err_overflow, err_underflow}, 8'h00);
    check("mid-reset fd", fd, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    idle();
    check("post-reset flags", {5'b0, flags}, 8'h02);
    check("post-reset in_valid", {7'b0, host_in_valid}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fx2_fifo_emu.md
# fx2_fifo_emu

Synthesizable model of the FX2 side of the slave-FIFO interface, the counterpart of the FPGA's FX2 bus master. It answers `fx2_slrd`/`fx2_slwr`/`fx2_sloe`/`fx2_pktend`/`fx2_fifoadr` with FIFO-backed `fx2_fd` data and `fx2_flags`, exactly as the FX2 chip does. A simple host-side port stands in for USB endpoints, so command/sample loopback runs in simulation and on-board without the FX2 chip.

## Interface
- `OUT_DEPTH`, 16: host→FPGA (OUT endpoint) FIFO depth in bytes; power of two, ≥2.
- `IN_DEPTH`, 16: FPGA→host (IN endpoint) FIFO depth in entries; power of two, ≥2.
- `OUT_ADDR`, 2'b00: `fx2_fifoadr` value selecting the OUT endpoint.
- `IN_ADDR`, 2'b10: `fx2_fifoadr` value selecting the IN endpoint.

Ports:
- `fx2_clk` in 1: the single clock; all state changes on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `fx2_slrd` in 1: active-low read strobe.
- `fx2_slwr` in 1: active-low write strobe.
- `fx2_sloe` in 1: active-low output enable for `fx2_fd`.
- `fx2_pktend` in 1: active-low packet commit.
- `fx2_fifoadr` in 2: endpoint select.
- `fx2_fd` inout 8: data bus.
- `fx2_flags` out 3:
  - [0] OUT not-empty.
  - [1] IN not-full.
  - [2] IN not-empty.
- `host_out_data` in 8: byte to enqueue in the OUT FIFO.
- `host_out_wr` in 1: push strobe for the OUT FIFO.
- `host_out_full` out 1: OUT FIFO full.
- `host_in_data` out 8: head byte of the IN FIFO.
- `host_in_last` out 1: head byte ends a packet.
- `host_in_valid` out 1: IN FIFO non-empty.
- `host_in_rd` in 1: pop strobe for the IN FIFO.
- `zlp_count` out 8: count of zero-length packets, wraps.
- `err_overflow` out 1: sticky; set by a write while IN is full.
- `err_underflow` out 1: sticky; set by a read while OUT is empty.

## Operation
- **Bus drive.** `fx2_fd` is driven only when `fx2_sloe`=0 and `fx2_fifoadr`=`OUT_ADDR`.
  - Drives the OUT head byte, or 8'h00 if OUT is empty.
  - Otherwise `fx2_fd` is high-Z.
  - The drive path is combinational from the head register.
- **FPGA read.** On an edge with `fx2_slrd`=0 and `fx2_fifoadr`=`OUT_ADDR`:
  - OUT not empty: pop one byte.
  - OUT empty: no pop; set `err_underflow`.
- **FPGA write.** On an edge with `fx2_slwr`=0 and `fx2_fifoadr`=`IN_ADDR`:
  - IN not full: push {eop, `fx2_fd`}, with eop = (`fx2_pktend`==0).
  - IN full: drop the byte; set `err_overflow`.
- **Packet commit.** On an edge with `fx2_pktend`=0, `fx2_slwr`=1 and `fx2_fifoadr`=`IN_ADDR`:
  - IN non-empty: set eop on the newest entry (tail−1), even if it already has eop.
  - IN empty: increment `zlp_count`; nothing is enqueued.
- **Wrong address.** Strobes with `fx2_fifoadr` not matching the relevant endpoint are ignored and are not errors.
- **Host OUT push.** `host_out_wr`=1 while not full pushes `host_out_data`. A push while full is dropped and does not set an error flag.
- **Host IN pop.** `host_in_rd`=1 while `host_in_valid`=1 pops. A pop while empty is ignored.
- **Simultaneous push and pop on one FIFO.** Allowed in the same cycle:
  - Not empty: occupancy is unchanged.
  - Empty: the pop is rejected and the push lands.
  - Full: the push is rejected even though a pop occurs in the same cycle.
- **Pointers and occupancy.** Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy counters are log2(DEPTH)+1 bits.
- **Clearing errors.** Error flags are cleared only by reset.

## Timing
- **Reset values.**
  - `fx2_flags`=3'b010.
  - `host_out_full`=0, `host_in_valid`=0, `host_in_last`=0, `host_in_data`=8'h00.
  - `zlp_count`=0; both error flags 0.
  - `fx2_fd` high-Z; all FIFOs empty.
- **Reset mid-operation.** Reset asserted at any time empties both FIFOs immediately (asynchronously) and discards pending data.
- **Flags.** `fx2_flags` and `host_out_full` are registered, computed from post-edge occupancy.
  - They are valid in the cycle after the operation that changed them, with no additional lag.
  - A write at occupancy IN_DEPTH−1 drives `fx2_flags[1]` to 0 from the next cycle.
- **Read latency.** `fx2_fd` presents the new head in the cycle after a pop.
  - Back-to-back `fx2_slrd` low for N cycles pops N bytes, limited to the occupancy.
- **Host IN path.**
  - `host_in_valid`, `host_in_data` and `host_in_last` are registered and reflect the head the cycle after a push into an empty FIFO.
  - A pop advances to the next entry the following cycle.
- **Throughput.** One byte per cycle per direction, sustained.

## Test plan
- **OUT path.** After reset, host pushes 8'hA1, 8'hB2, 8'hC3. Then hold `fx2_fifoadr`=00, `fx2_sloe`=0, `fx2_slrd`=0 for 3 cycles.
  - `fx2_fd` shows A1, B2, C3 on successive cycles.
  - `fx2_flags[0]` goes 1→0 one cycle after the third pop.
- **IN path.** `fx2_fifoadr`=10; write 0x10..0x13 with `fx2_pktend`=0 on the last write.
  - Host reads 10,11,12,13 with `host_in_last`=0,0,0,1.
- **Standalone pktend.** Pktend alone with IN empty → `zlp_count`=1, `host_in_valid` stays 0. Write 0x55, then pktend alone → the 0x55 entry reads back with `host_in_last`=1.
- **Full/overflow.** Write IN_DEPTH+1 bytes with no host reads.
  - `fx2_flags[1]`=0 after the 16th write.
  - The 17th byte is dropped and `err_overflow`=1.
  - Host drains exactly 16 bytes, first in first out.
- **Underflow and wrap-around.** Read with OUT empty → `err_underflow`=1, `fx2_fd`=00. Then run 40 bytes through OUT with the host pushing and the FPGA popping simultaneously every cycle → all 40 bytes arrive in order with no flag glitches.
- **Reset mid-transfer.** Assert `reset_n`=0 with 5 bytes in each FIFO → all outputs return to their reset values immediately, including `fx2_flags`=010.
